shift_add_multiplier: RTL and testbench

Sequential unsigned shift-and-add multiplier. It is the inverse companion of the restoring divider and shares the same narrow-bus protocol: operands are loaded serially over bus_in after start, the product is computed over WIDTH iterations, and the 2*WIDTH-bit result is returned on bus_out as two beats (high half, then low half). It sits beside the divider on the same datapath bus, with an identical start/done/flag handshake.

---
 rtl/shift_add_multiplier.sv | 179 +++++++++++++++++
 tb/tb_shift_add_multiplier.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//
// Sequential unsigned shift-and-add multiplier sharing the narrow-bus
// start/done/flag handshake of the restoring divider. Operands arrive
// serially on bus_in (multiplicand with start, multiplier one cycle later).
// The product is computed over WIDTH iterations and returned on bus_out as
// two beats: high half, then low half.
//
// Parameters:
//   WIDTH          operand and bus width; product is 2*WIDTH bits
//
// Ports:
//   clk            system clock, rising-edge active
//   rst            synchronous reset, active-high
//   bus_in         operand bus (multiplicand in start cycle, multiplier next)
//   start          begin operation; sampled only when idle
//   bus_out        product beat: high half in OUT_HI, low half in OUT_LO
//   done           high during both output beats
//   out_hi         high during the high-half beat
//   busy           high whenever not idle
//   zero_flag      product == 0; valid from OUT_HI until next accepted start
//   overflow_flag  product high half != 0; same validity as zero_flag
//
// Build option:
//   MUL_ZERO_SKIP_EN  when defined, a zero operand skips the iteration phase
//                     and jumps straight to the output beats.
// ---------------------------------------------------------------------------
module shift_add_multiplier #(
   parameter int unsigned WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] bus_in,
   input  logic             start,
   output logic [WIDTH-1:0] bus_out,
   output logic             done,
   output logic             out_hi,
   output logic             busy,
   output logic             zero_flag,
   output logic             overflow_flag
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_B,
      S_CALC,
      S_OUT_HI,
      S_OUT_LO
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_p;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_bus_out;
   logic             r_done;
   logic             r_out_hi;
   logic             r_busy;
   logic             r_zero;
   logic             r_ovf;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_p_next;
   logic [WIDTH-1:0] w_q_next;
   logic             w_last;

   // One iteration: conditionally add the multiplicand into the accumulator,
   // then shift {carry, sum, Q} right by one. The carry lands in the MSB of P
   // and the sum LSB moves into the vacated MSB of Q.
   always_comb begin
      w_sum    = {1'b0, r_p} + (r_q[0] ? {1'b0, r_a} : '0);
      w_p_next = w_sum[WIDTH:1];
      w_q_next = {w_sum[0], r_q[WIDTH-1:1]};
      w_last   = (r_cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_a       <= '0;
         r_q       <= '0;
         r_p       <= '0;
         r_cnt     <= '0;
         r_bus_out <= '0;
         r_done    <= 1'b0;
         r_out_hi  <= 1'b0;
         r_busy    <= 1'b0;
         r_zero    <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Flags keep the previous result until a new operation is taken.
               if (start) begin
                  r_a     <= bus_in;
                  r_p     <= '0;
                  r_cnt   <= '0;
                  r_zero  <= 1'b0;
                  r_ovf   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_LOAD_B;
               end
            end

            S_LOAD_B: begin
`ifdef MUL_ZERO_SKIP_EN
               if ((r_a == '0) || (bus_in == '0)) begin
                  r_p       <= '0;
                  r_q       <= '0;
                  r_zero    <= 1'b1;
                  r_ovf     <= 1'b0;
                  r_bus_out <= '0;
                  r_done    <= 1'b1;
                  r_out_hi  <= 1'b1;
                  r_state   <= S_OUT_HI;
               end else begin
                  r_q     <= bus_in;
                  r_state <= S_CALC;
               end
`else
               r_q     <= bus_in;
               r_state <= S_CALC;
`endif
            end

            S_CALC: begin
               r_p   <= w_p_next;
               r_q   <= w_q_next;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  // Flags and the high beat come from the final product
                  // directly so they are registered on entry to OUT_HI.
                  r_zero    <= ({w_p_next, w_q_next} == '0);
                  r_ovf     <= (w_p_next != '0);
                  r_bus_out <= w_p_next;
                  r_done    <= 1'b1;
                  r_out_hi  <= 1'b1;
                  r_state   <= S_OUT_HI;
               end
            end

            S_OUT_HI: begin
               r_bus_out <= r_q;
               r_done    <= 1'b1;
               r_out_hi  <= 1'b0;
               r_state   <= S_OUT_LO;
            end

            S_OUT_LO: begin
               r_bus_out <= '0;
               r_done    <= 1'b0;
               r_out_hi  <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= S_IDLE;
            end

            default: begin
               r_bus_out <= '0;
               r_done    <= 1'b0;
               r_out_hi  <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign bus_out       = r_bus_out;
   assign done          = r_done;
   assign out_hi        = r_out_hi;
   assign busy          = r_busy;
   assign zero_flag     = r_zero;
   assign overflow_flag = r_ovf;

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

   localparam int unsigned W = 5;
`ifdef MUL_ZERO_SKIP_EN
   localparam int EXP_LAT_ZERO = 2;
`else
   localparam int EXP_LAT_ZERO = 7;
`endif

   logic         clk;
   logic         rst;
   logic [W-1:0] bus_in;
   logic         start;
   logic [W-1:0] bus_out;
   logic         done;
   logic         out_hi;
   logic         busy;
   logic         zero_flag;
   logic         overflow_flag;

   int n_checks = 0;
   int n_fail   = 0;

   shift_add_multiplier #(.WIDTH(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus_in        (bus_in),
      .start         (start),
      .bus_out       (bus_out),
      .done          (done),
      .out_hi        (out_hi),
      .busy          (busy),
      .zero_flag     (zero_flag),
      .overflow_flag (overflow_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs are driven and outputs sampled at the falling edge. Cycle t is
   // the cycle in which start is high; the loop samples cycles t+2 onward.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inj_start_cyc,
                         output logic [W-1:0] hi, output logic [W-1:0] lo,
                         output logic zf, output logic of, output int lat_hi);
      bit got_lo;
      hi = '0; lo = '0; zf = 1'b0; of = 1'b0; lat_hi = -1; got_lo = 1'b0;
      @(negedge clk);
      start = 1'b1; bus_in = a;
      @(negedge clk);
      start = 1'b0; bus_in = b;
      n_checks++;
      if ({busy, done, zero_flag, overflow_flag} !== 4'b1000) begin
         n_fail++;
         $display("FAIL load_b_state: busy/done/zf/of = %b, expected 1000", {busy, done, zero_flag, overflow_flag});
      end
      for (int k = 2; k < 20 && !got_lo; k++) begin
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_op: cycle t+%0d busy=%b expected 1", k, busy);
         end
         if (done === 1'b1 && out_hi === 1'b1) begin
            lat_hi = k; hi = bus_out; zf = zero_flag; of = overflow_flag;
         end else if (done === 1'b1 && out_hi === 1'b0) begin
            lo = bus_out; got_lo = 1'b1;
            n_checks++;
            if (lat_hi < 0 || k != lat_hi + 1) begin
               n_fail++;
               $display("FAIL lo_follows_hi: lo at t+%0d, hi at t+%0d", k, lat_hi);
            end
         end
         start  = (k == inj_start_cyc);
         bus_in = (k == inj_start_cyc) ? 5'd9 : 5'd0;
      end
      start = 1'b0;
      if (!got_lo) begin
         n_checks++; n_fail++;
         $display("FAIL op_timeout: no low beat within bound for %0d*%0d", a, b);
      end
   endtask

   task automatic check_result(input string name,
                               input logic [W-1:0] hi, input logic [W-1:0] lo,
                               input logic zf, input logic of, input int lat,
                               input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                               input logic e_zf, input logic e_of, input int e_lat);
      n_checks++;
      if (hi !== e_hi) begin n_fail++; $display("FAIL %s_hi: got %0d expected %0d", name, hi, e_hi); end
      n_checks++;
      if (lo !== e_lo) begin n_fail++; $display("FAIL %s_lo: got %0d expected %0d", name, lo, e_lo); end
      n_checks++;
      if (zf !== e_zf) begin n_fail++; $display("FAIL %s_zero_flag: got %b expected %b", name, zf, e_zf); end
      n_checks++;
      if (of !== e_of) begin n_fail++; $display("FAIL %s_overflow_flag: got %b expected %b", name, of, e_of); end
      n_checks++;
      if (lat !== e_lat) begin n_fail++; $display("FAIL %s_latency: OUT_HI at t+%0d expected t+%0d", name, lat, e_lat); end
   endtask

   task automatic check_idle(input string name);
      n_checks++;
      if ({busy, done, out_hi, bus_out} !== {3'b000, 5'd0}) begin
         n_fail++;
         $display("FAIL %s: busy=%b done=%b out_hi=%b bus_out=%0d expected all 0", name, busy, done, out_hi, bus_out);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; bus_in = 5'd31;
      repeat (3) @(negedge clk);
      check_idle("reset_outputs");
      n_checks++;
      if ({zero_flag, overflow_flag} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_flags: zf/of=%b expected 00", {zero_flag, overflow_flag});
      end
      rst = 1'b0; start = 1'b0; bus_in = '0;
      @(negedge clk);
      check_idle("reset_release_idle");
   endtask

   task automatic test_max();
      logic [W-1:0] hi, lo; logic zf, of; int lat;
      run_op(5'd31, 5'd31, -1, hi, lo, zf, of, lat);
      check_result("max_31x31", hi, lo, zf, of, lat, 5'd30, 5'd1, 1'b0, 1'b1, 7);
      @(negedge clk);
      check_idle("max_busy_drop");
   endtask

   task automatic test_flag_hold();
      logic [W-1:0] hi, lo; logic zf, of; int lat;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({zero_flag, overflow_flag} !== 2'b01) begin
         n_fail++;
         $display("FAIL flag_hold_idle: zf/of=%b expected 01", {zero_flag, overflow_flag});
      end
      run_op(5'd6, 5'd5, -1, hi, lo, zf, of, lat);
      check_result("mul_6x5", hi, lo, zf, of, lat, 5'd0, 5'd30, 1'b0, 1'b0, 7);
   endtask

   task automatic test_zero();
      logic [W-1:0] hi, lo; logic zf, of; int lat;
      run_op(5'd0, 5'd17, -1, hi, lo, zf, of, lat);
      check_result("zero_0x17", hi, lo, zf, of, lat, 5'd0, 5'd0, 1'b1, 1'b0, EXP_LAT_ZERO);
   endtask

   task automatic test_start_ignored();
      logic [W-1:0] hi, lo; logic zf, of; int lat;
      run_op(5'd3, 5'd7, 3, hi, lo, zf, of, lat);
      check_result("ignore_start_3x7", hi, lo, zf, of, lat, 5'd0, 5'd21, 1'b0, 1'b0, 7);
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] hi, lo; logic zf, of; int lat;
      bit saw_done;
      @(negedge clk);
      start = 1'b1; bus_in = 5'd31;
      @(negedge clk);
      start = 1'b0; bus_in = 5'd31;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle("mid_reset_outputs");
      n_checks++;
      if ({zero_flag, overflow_flag} !== 2'b00) begin
         n_fail++;
         $display("FAIL mid_reset_flags: zf/of=%b expected 00", {zero_flag, overflow_flag});
      end
      saw_done = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
      end
      n_checks++;
      if (saw_done) begin
         n_fail++;
         $display("FAIL mid_reset_no_done: activity seen %b expected %b", saw_done, 1'b0);
      end
      run_op(5'd2, 5'd3, -1, hi, lo, zf, of, lat);
      check_result("after_reset_2x3", hi, lo, zf, of, lat, 5'd0, 5'd6, 1'b0, 1'b0, 7);
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] hi, lo; logic zf, of; int lat;
      run_op(5'd2, 5'd3, -1, hi, lo, zf, of, lat);
      check_result("b2b_first_2x3", hi, lo, zf, of, lat, 5'd0, 5'd6, 1'b0, 1'b0, 7);
      run_op(5'd4, 5'd8, -1, hi, lo, zf, of, lat);
      check_result("b2b_second_4x8", hi, lo, zf, of, lat, 5'd1, 5'd0, 1'b0, 1'b1, 7);
      @(negedge clk);
      check_idle("b2b_final_idle");
      n_checks++;
      if ({zero_flag, overflow_flag} !== 2'b01) begin
         n_fail++;
         $display("FAIL b2b_flag_hold: zf/of=%b expected 01", {zero_flag, overflow_flag});
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; bus_in = '0;
      test_reset();
      test_max();
      test_flag_hold();
      test_zero();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
